// File: rtl/ibex_vec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ibex_vec_pkg
// Brief   : Shared vector-unit types, constants and the register-group mask
//           helper used by writeback arbitration, scoreboard and decode.
// Revision: 1.0 - initial release
// ============================================================================
package ibex_vec_pkg;

    // Architectural sizes of the vector register file
    localparam int unsigned NREG   = 32;
    localparam int unsigned DATA_W = 128;

    // Register group multiplier encodings; remaining codes are illegal
    typedef enum logic [2:0] {
        VLMUL_1 = 3'b000,
        VLMUL_2 = 3'b001,
        VLMUL_4 = 3'b010
    } vlmul_e;

    // Selected element width encodings
    typedef enum logic [1:0] {
        VSEW_8  = 2'b00,
        VSEW_16 = 2'b01,
        VSEW_32 = 2'b10,
        VSEW_64 = 2'b11
    } vsew_e;

    // One-hot set of registers covered by the group that contains addr.
    // Register 0 is never tracked, so its bit is always cleared.
    function automatic logic [NREG-1:0] vreg_group_mask(
        input logic [4:0] addr,
        input logic [2:0] vlmul
    );
        logic [NREG-1:0] m;
        m = '0;
        case (vlmul)
            VLMUL_1: begin
                m[addr] = 1'b1;
            end
            VLMUL_2: begin
                m[{addr[4:1], 1'b0}] = 1'b1;
                m[{addr[4:1], 1'b1}] = 1'b1;
            end
            VLMUL_4: begin
                m[{addr[4:2], 2'b00}] = 1'b1;
                m[{addr[4:2], 2'b01}] = 1'b1;
                m[{addr[4:2], 2'b10}] = 1'b1;
                m[{addr[4:2], 2'b11}] = 1'b1;
            end
            default: begin
                m = '0;
            end
        endcase
        m[0] = 1'b0;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_vrf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : ibex_vrf_scoreboard
// Brief   : Pending-write tracker over vector register groups. Sets groups
//           at issue, clears them at write commit, and reports WAW blocking
//           and RAW hazards on up to three read ports.
// Revision: 1.0 - initial release
// ============================================================================
module ibex_vrf_scoreboard
    import ibex_vec_pkg::*;
#(
    parameter int unsigned NREG_P = ibex_vec_pkg::NREG
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [2:0]  vlmul_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_waddr_i,
    output logic        issue_ready_o,
    input  logic        clr_en_i,
    input  logic [4:0]  clr_addr_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    input  logic [4:0]  raddr_c_i,
    input  logic [2:0]  rd_en_i,
    output logic        hazard_o
);

    logic [NREG_P-1:0] r_pending;
    logic [NREG_P-1:0] w_issue_mask;
    logic [NREG_P-1:0] w_set_mask;
    logic [NREG_P-1:0] w_clr_mask;
    logic              w_issue_ready;
    logic [4:0]        w_raddr [3];
    logic [2:0]        w_port_hit;

    assign w_raddr[0] = raddr_a_i;
    assign w_raddr[1] = raddr_b_i;
    assign w_raddr[2] = raddr_c_i;

    // Issue is blocked while any register of its destination group is pending
    always_comb begin
        w_issue_mask  = vreg_group_mask(issue_waddr_i, vlmul_i);
        w_issue_ready = ((w_issue_mask & r_pending) == '0);
        w_set_mask    = (issue_valid_i && w_issue_ready) ? w_issue_mask : '0;
        w_clr_mask    = clr_en_i ? vreg_group_mask(clr_addr_i, vlmul_i) : '0;
    end

    // Clear first, then set, so a same-cycle issue keeps its bits pending
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    // Per read port: enabled source overlapping a pending group
    generate
        for (genvar p = 0; p < 3; p++) begin : g_rd_port
            assign w_port_hit[p] = rd_en_i[p] &&
                                   (|(vreg_group_mask(w_raddr[p], vlmul_i) & r_pending));
        end
    endgenerate

    assign issue_ready_o = w_issue_ready;
    assign hazard_o      = |w_port_hit;

    // Group masks are only meaningful if vlmul is stable while writes are pending
    a_vlmul_stable: assert property (
        @(posedge clk_i) disable iff (!rstn_i)
        (r_pending != '0) |-> $stable(vlmul_i)
    );

endmodule
`default_nettype wire

// File: rtl/ibex_vrf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ibex_vrf_wb_arbiter
// Brief   : Shares the vector register file write port between the vector
//           ALU and the vector load unit (round-robin or load-priority), with
//           a single registered output stage and a pending-write scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module ibex_vrf_wb_arbiter
    import ibex_vec_pkg::*;
#(
    parameter int unsigned DATA_W   = ibex_vec_pkg::DATA_W,
    parameter int unsigned NREG     = ibex_vec_pkg::NREG,
    parameter int unsigned LSU_PRIO = 0
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [2:0]        vlmul_i,
    // ALU writeback request
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [DATA_W-1:0] alu_wdata_i,
    input  logic [4:0]        alu_waddr_i,
    input  logic [3:0]        alu_wnum_i,
    // Load unit writeback request
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic [4:0]        lsu_waddr_i,
    // Register file write port
    output logic              v_we_o,
    output logic [DATA_W-1:0] v_wdata_o,
    output logic [4:0]        v_waddr_o,
    output logic [3:0]        v_wnum_o,
    output logic              v_load_en_o,
    // Decode interface
    input  logic              issue_valid_i,
    input  logic [4:0]        issue_waddr_i,
    output logic              issue_ready_o,
    input  logic [4:0]        raddr_a_i,
    input  logic [4:0]        raddr_b_i,
    input  logic [4:0]        raddr_c_i,
    input  logic [2:0]        rd_en_i,
    output logic              hazard_o
);

    localparam logic [3:0] c_WNUM_FULL = 4'b1111;
    localparam logic       c_LSU_PRIO  = (LSU_PRIO != 0);

    logic              r_rr_lsu;     // 1: load unit wins the next conflict
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [4:0]        r_waddr;
    logic [3:0]        r_wnum;
    logic              r_load_en;

    logic              w_conflict;
    logic              w_lsu_wins;
    logic              w_gnt_alu;
    logic              w_gnt_lsu;
    logic              w_accept;
    logic [4:0]        w_sel_addr;

    // Grant is purely a function of the current requests and the pointer
    always_comb begin
        w_conflict = alu_valid_i && lsu_valid_i;
        w_lsu_wins = c_LSU_PRIO || r_rr_lsu;
        w_gnt_alu  = alu_valid_i && !(lsu_valid_i && w_lsu_wins);
        w_gnt_lsu  = lsu_valid_i && !w_gnt_alu;
        w_accept   = w_gnt_alu || w_gnt_lsu;
        w_sel_addr = w_gnt_lsu ? lsu_waddr_i : alu_waddr_i;
    end

    assign alu_ready_o = w_gnt_alu;
    assign lsu_ready_o = w_gnt_lsu;

    // Pointer moves only when a conflict is resolved: loser of this one wins next
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rr_lsu <= 1'b0;
        end else if (w_conflict) begin
            r_rr_lsu <= w_gnt_alu;
        end
    end

    // Output stage: capture the granted payload; writes to v0 are swallowed
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_waddr   <= '0;
            r_wnum    <= '0;
            r_load_en <= 1'b0;
        end else if (w_accept) begin
            r_we      <= (w_sel_addr != 5'd0);
            r_waddr   <= w_sel_addr;
            r_wdata   <= w_gnt_lsu ? lsu_wdata_i : alu_wdata_i;
            r_wnum    <= w_gnt_lsu ? c_WNUM_FULL : alu_wnum_i;
            r_load_en <= w_gnt_lsu;
        end else begin
            r_we      <= 1'b0;
        end
    end

    assign v_we_o      = r_we;
    assign v_wdata_o   = r_wdata;
    assign v_waddr_o   = r_waddr;
    assign v_wnum_o    = r_wnum;
    assign v_load_en_o = r_load_en;

    // Pending groups are released when the write actually reaches the file
    ibex_vrf_scoreboard #(
        .NREG_P        (NREG)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .vlmul_i       (vlmul_i),
        .issue_valid_i (issue_valid_i),
        .issue_waddr_i (issue_waddr_i),
        .issue_ready_o (issue_ready_o),
        .clr_en_i      (r_we),
        .clr_addr_i    (r_waddr),
        .raddr_a_i     (raddr_a_i),
        .raddr_b_i     (raddr_b_i),
        .raddr_c_i     (raddr_c_i),
        .rd_en_i       (rd_en_i),
        .hazard_o      (hazard_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_ibex_vrf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ibex_vrf_wb_arbiter
// Brief   : Directed self-checking bench for the vector writeback arbiter,
//           with a write scoreboard queue and a pending-register model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ibex_vrf_wb_arbiter;

    localparam int unsigned c_LSU_PRIO = 0;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic [2:0]   vlmul_i;
    logic         alu_valid_i, alu_ready_o;
    logic [127:0] alu_wdata_i;
    logic [4:0]   alu_waddr_i;
    logic [3:0]   alu_wnum_i;
    logic         lsu_valid_i, lsu_ready_o;
    logic [127:0] lsu_wdata_i;
    logic [4:0]   lsu_waddr_i;
    logic         v_we_o;
    logic [127:0] v_wdata_o;
    logic [4:0]   v_waddr_o;
    logic [3:0]   v_wnum_o;
    logic         v_load_en_o;
    logic         issue_valid_i, issue_ready_o;
    logic [4:0]   issue_waddr_i;
    logic [4:0]   raddr_a_i, raddr_b_i, raddr_c_i;
    logic [2:0]   rd_en_i;
    logic         hazard_o;

    always #5 clk_i = ~clk_i;

    ibex_vrf_wb_arbiter #(
        .DATA_W   (128),
        .NREG     (32),
        .LSU_PRIO (c_LSU_PRIO)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .vlmul_i       (vlmul_i),
        .alu_valid_i   (alu_valid_i),
        .alu_ready_o   (alu_ready_o),
        .alu_wdata_i   (alu_wdata_i),
        .alu_waddr_i   (alu_waddr_i),
        .alu_wnum_i    (alu_wnum_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_waddr_i   (lsu_waddr_i),
        .v_we_o        (v_we_o),
        .v_wdata_o     (v_wdata_o),
        .v_waddr_o     (v_waddr_o),
        .v_wnum_o      (v_wnum_o),
        .v_load_en_o   (v_load_en_o),
        .issue_valid_i (issue_valid_i),
        .issue_waddr_i (issue_waddr_i),
        .issue_ready_o (issue_ready_o),
        .raddr_a_i     (raddr_a_i),
        .raddr_b_i     (raddr_b_i),
        .raddr_c_i     (raddr_c_i),
        .rd_en_i       (rd_en_i),
        .hazard_o      (hazard_o)
    );

    typedef struct {
        logic         we;
        logic [4:0]   addr;
        logic [3:0]   wnum;
        logic         load;
        logic [127:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic        m_pref_lsu;
    logic [31:0] m_pend;
    logic        m_cur_we;
    logic [4:0]  m_cur_addr;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Independent formulation of the register-group coverage
    function automatic logic [31:0] gmask(input logic [4:0] a, input logic [2:0] vl);
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < 32; i++) begin
            case (vl)
                3'b000:  m[i] = (i == int'(a));
                3'b001:  m[i] = ((i / 2) == (int'(a) / 2));
                3'b010:  m[i] = ((i / 4) == (int'(a) / 4));
                default: m[i] = 1'b0;
            endcase
        end
        return m;
    endfunction

    // One clock: check combinational outputs, push expected write, advance,
    // then pop and compare the registered write port.
    task automatic tick(input string tag);
        wr_t         e;
        logic        ga, gl, ir, hz;
        logic [31:0] setm, clrm;
        #1;
        ga = alu_valid_i && !(lsu_valid_i && ((c_LSU_PRIO != 0) || m_pref_lsu));
        gl = lsu_valid_i && !ga;
        check({tag, ":alu_ready"}, alu_ready_o, ga);
        check({tag, ":lsu_ready"}, lsu_ready_o, gl);
        ir = ((gmask(issue_waddr_i, vlmul_i) & m_pend) == 32'd0);
        hz = (rd_en_i[0] && (|(gmask(raddr_a_i, vlmul_i) & m_pend))) ||
             (rd_en_i[1] && (|(gmask(raddr_b_i, vlmul_i) & m_pend))) ||
             (rd_en_i[2] && (|(gmask(raddr_c_i, vlmul_i) & m_pend)));
        check({tag, ":issue_ready"}, issue_ready_o, ir);
        check({tag, ":hazard"}, hazard_o, hz);
        e.we = 1'b0; e.addr = '0; e.wnum = '0; e.load = 1'b0; e.data = '0;
        if (ga) begin
            e.we = (alu_waddr_i != 5'd0); e.addr = alu_waddr_i; e.wnum = alu_wnum_i;
            e.load = 1'b0; e.data = alu_wdata_i;
        end else if (gl) begin
            e.we = (lsu_waddr_i != 5'd0); e.addr = lsu_waddr_i; e.wnum = 4'b1111;
            e.load = 1'b1; e.data = lsu_wdata_i;
        end
        exp_q.push_back(e);
        if (alu_valid_i && lsu_valid_i) m_pref_lsu = ga;
        setm   = (issue_valid_i && ir) ? gmask(issue_waddr_i, vlmul_i) : 32'd0;
        clrm   = m_cur_we ? gmask(m_cur_addr, vlmul_i) : 32'd0;
        m_pend = (m_pend & ~clrm) | setm;
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        check({tag, ":v_we"}, v_we_o, e.we);
        if (e.we) begin
            check({tag, ":v_waddr"}, v_waddr_o, e.addr);
            check({tag, ":v_wnum"}, v_wnum_o, e.wnum);
            check({tag, ":v_load_en"}, v_load_en_o, e.load);
            check({tag, ":v_wdata"}, v_wdata_o, e.data);
        end
        m_cur_we   = e.we;
        m_cur_addr = e.addr;
    endtask

    initial begin
        rstn_i = 1'b0; vlmul_i = 3'b000;
        alu_valid_i = 0; alu_wdata_i = '0; alu_waddr_i = '0; alu_wnum_i = '0;
        lsu_valid_i = 0; lsu_wdata_i = '0; lsu_waddr_i = '0;
        issue_valid_i = 0; issue_waddr_i = '0;
        raddr_a_i = '0; raddr_b_i = '0; raddr_c_i = '0; rd_en_i = '0;
        m_pref_lsu = 1'b0; m_pend = '0; m_cur_we = 1'b0; m_cur_addr = '0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst:v_we", v_we_o, 1'b0);
        check("rst:v_wdata", v_wdata_o, 128'd0);
        check("rst:v_waddr", v_waddr_o, 5'd0);
        check("rst:v_wnum", v_wnum_o, 4'd0);
        check("rst:v_load_en", v_load_en_o, 1'b0);
        check("rst:issue_ready", issue_ready_o, 1'b1);
        rstn_i = 1'b1;

        // ALU alone: same-cycle grant, one-cycle write pulse
        alu_valid_i = 1; alu_waddr_i = 5'd5; alu_wnum_i = 4'b0011;
        alu_wdata_i = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
        tick("alu_only");
        alu_valid_i = 0;
        tick("alu_idle");

        // Conflict for four cycles: ALU, LSU, ALU, LSU
        alu_valid_i = 1; alu_waddr_i = 5'd10; alu_wnum_i = 4'b1111;
        alu_wdata_i = 128'hBBBB_BBBB_0000_0001_0000_0002_0000_0003;
        lsu_valid_i = 1; lsu_waddr_i = 5'd20;
        lsu_wdata_i = 128'hCCCC_CCCC_1234_5678_9ABC_DEF0_0F0F_F0F0;
        tick("rr0");
        check("rr0:granted_alu", v_load_en_o, 1'b0);
        tick("rr1");
        check("rr1:granted_lsu", v_load_en_o, 1'b1);
        tick("rr2");
        tick("rr3");
        alu_valid_i = 0; lsu_valid_i = 0;
        tick("rr_idle");

        // Grouped scoreboard, vlmul=2: issue to 6 marks 6 and 7
        vlmul_i = 3'b001;
        issue_valid_i = 1; issue_waddr_i = 5'd6;
        rd_en_i = 3'b001; raddr_a_i = 5'd7;
        tick("issue6");
        issue_valid_i = 0;
        tick("haz7");
        check("haz7:hazard_direct", hazard_o, 1'b1);
        issue_valid_i = 1; issue_waddr_i = 5'd7;
        tick("waw7");
        issue_valid_i = 0;
        lsu_valid_i = 1; lsu_waddr_i = 5'd6;
        lsu_wdata_i = 128'hDDDD_0000_DDDD_0000_DDDD_0000_DDDD_0000;
        tick("ld6");
        lsu_valid_i = 0;
        tick("commit6");
        tick("after6");
        check("after6:hazard_direct", hazard_o, 1'b0);
        vlmul_i = 3'b000;

        // Load to v0: accepted, no write pulse, scoreboard untouched
        lsu_valid_i = 1; lsu_waddr_i = 5'd0;
        lsu_wdata_i = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;
        tick("ld0");
        lsu_valid_i = 0;
        tick("ld0_idle");

        // Issue to 4 in the same cycle a write to 4 commits: set wins
        alu_valid_i = 1; alu_waddr_i = 5'd4; alu_wnum_i = 4'b0001;
        alu_wdata_i = 128'h0000_0000_0000_0000_0000_0000_4444_4444;
        tick("alu4");
        alu_valid_i = 0;
        issue_valid_i = 1; issue_waddr_i = 5'd4;
        tick("issue4_commit");
        issue_valid_i = 0; raddr_a_i = 5'd4; rd_en_i = 3'b001;
        tick("haz4");
        check("haz4:hazard_direct", hazard_o, 1'b1);

        // Conflict wins ALU (pointer now LSU), then reset while write in flight
        alu_valid_i = 1; alu_waddr_i = 5'd9; alu_wnum_i = 4'b0111;
        alu_wdata_i = 128'h9999_9999_9999_9999_9999_9999_9999_9999;
        lsu_valid_i = 1; lsu_waddr_i = 5'd21;
        tick("rst_pre");
        rstn_i = 1'b0;
        #1;
        check("rst_mid:v_we", v_we_o, 1'b0);
        check("rst_mid:hazard", hazard_o, 1'b0);
        check("rst_mid:issue_ready", issue_ready_o, 1'b1);
        m_pend = '0; m_pref_lsu = 1'b0; m_cur_we = 1'b0; m_cur_addr = '0;
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        tick("post_rst");
        check("post_rst:alu_first", v_load_en_o, 1'b0);
        alu_valid_i = 0; lsu_valid_i = 0;
        tick("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ibex_vrf_wb_arbiter.md
Name: ibex_vrf_wb_arbiter

Overview:
- Shares the single 128-bit vector register file write port between two producers: the vector ALU writeback and the vector load unit.
- Round-robin arbitration over valid/ready handshakes, with one registered output stage that drives the register file write controls.
- Keeps a 32-entry pending-write scoreboard over destination register groups. Decode uses it for RAW hazard detection on the three read ports and for WAW blocking at issue.

Parameters:
- DATA_W, 128, write data width (4 x 32-bit register slices).
- NREG, 32, number of vector registers.
- LSU_PRIO, 0, 0 = round-robin; 1 = load unit always wins a conflict.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- vlmul_i  in  3  group multiplier: 000 = 1, 001 = 2, 010 = 4; other codes are illegal.
- alu_valid_i  in  1  ALU write request.
- alu_ready_o  out  1  ALU request accepted this cycle.
- alu_wdata_i  in  DATA_W  ALU write data.
- alu_waddr_i  in  5  ALU destination register.
- alu_wnum_i  in  4  elements to write, thermometer code (0001/0011/0111/1111).
- lsu_valid_i  in  1  load write request.
- lsu_ready_o  out  1  load request accepted this cycle.
- lsu_wdata_i  in  DATA_W  load data.
- lsu_waddr_i  in  5  load destination register (group base).
- v_we_o  out  1  register file write enable.
- v_wdata_o  out  DATA_W  register file write data.
- v_waddr_o  out  5  register file write address.
- v_wnum_o  out  4  register file element count.
- v_load_en_o  out  1  selects load (whole-group) write mode.
- issue_valid_i  in  1  decode issuing an instruction with a vector destination.
- issue_waddr_i  in  5  destination of the issuing instruction.
- issue_ready_o  out  1  destination group has no pending write (no WAW).
- raddr_a_i, raddr_b_i, raddr_c_i  in  5 each  source registers being read.
- rd_en_i  in  3  per-port read-valid bits (bit0 = A, bit1 = B, bit2 = C).
- hazard_o  out  1  some enabled source overlaps a pending register.

Behaviour:
- Reset values:
  - v_we_o, v_load_en_o = 0; v_wdata_o, v_waddr_o, v_wnum_o = 0.
  - Scoreboard = 0; round-robin pointer = ALU-first.
- Arbitration:
  - Combinational grant. ready_o is high only for the granted valid requester.
  - Round-robin: on a conflict, the requester not granted last time wins. The pointer updates only on an accepted conflict.
  - LSU_PRIO=1: load always wins a conflict.
  - A lone requester is granted in the same cycle.
  - Requesters hold valid and payload stable until ready; ready never depends on a future cycle.
- Output stage and latency:
  - The output stage captures the granted payload on the accept edge.
  - v_we_o is high for exactly one cycle, on the cycle after accept, so write latency is 1 cycle.
  - Back-to-back accepts give back-to-back writes; there is no bubble because the register file writes in one cycle.
  - An ALU write drives v_load_en_o=0 and v_wnum_o=alu_wnum_i.
  - A load write drives v_load_en_o=1 and v_wnum_o=4'b1111.
- Register 0:
  - A request with waddr=0 is accepted; v_we_o stays 0 for it, and it does not touch the scoreboard.
- Group mask function G(addr, vlmul), over the scoreboard:
  - vlmul 000: bit addr.
  - vlmul 001: bits {addr[4:1], 0} and {addr[4:1], 1}.
  - vlmul 010: the four bits sharing addr[4:2].
  - Other codes: mask = 0.
  - Bit 0 of any mask is forced to 0.
- Scoreboard:
  - issue_ready_o = ((G(issue_waddr_i, vlmul_i) & pending) == 0).
  - An issue is accepted when issue_valid_i && issue_ready_o; it sets G(issue_waddr_i, vlmul_i).
  - A write clears G(v_waddr_o, vlmul_i) in the cycle v_we_o is high, i.e. at commit, not at accept.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Hazard:
  - hazard_o = OR over ports p with rd_en_i[p] of |(G(raddr_p, vlmul_i) & pending). Purely combinational.
  - The write-commit cycle still reports a hazard (no bypass); it drops the following cycle.
- vlmul_i changes only while the scoreboard is empty; behaviour otherwise is undefined and flagged by an assertion.
- Reset mid-operation: the in-flight output-stage write is discarded (v_we_o=0 immediately) and the scoreboard clears.

Decomposition:
- Shared package ibex_vec_pkg holds:
  - vlmul_e enum (VLMUL_1/2/4).
  - vsew_e enum.
  - Constants NREG and DATA_W.
  - Function vreg_group_mask(addr, vlmul), reused by decode.
- One sub-module is natural: ibex_vrf_scoreboard (pending vector, set/clear, WAW check, hazard check). The arbiter and output stage stay in the top module.

Test Plan:
- ALU only, waddr=5, wnum=0011, wdata=A: alu_ready_o=1 in the same cycle; next cycle v_we_o=1, v_waddr_o=5, v_wnum_o=0011, v_load_en_o=0, data=A; v_we_o=0 the cycle after.
- Both valid for 4 cycles, LSU_PRIO=0, pointer at reset: grants alternate ALU, LSU, ALU, LSU; v_load_en_o follows 0, 1, 0, 1.
- vlmul=001, issue waddr=6: pending bits 6 and 7 set; raddr_a=7 with rd_en=001 gives hazard_o=1; issue waddr=7 gives issue_ready_o=0; after the load write to 6 commits, hazard_o=0 the next cycle.
- Load request to waddr=0: accepted; v_we_o stays 0; scoreboard unchanged.
- Issue to 4 (vlmul=000) in the same cycle a pending write to 4 commits: bit 4 remains set.
- rstn_i asserted low the cycle after accept: v_we_o=0 immediately, scoreboard 0, and the next request is arbitrated ALU-first.
